wshb_stream_bridge: RTL and testbench
=====================================

# wshb_stream_bridge

Wishbone write-posting bridge between the video stream bus and the SDRAM bus, clocked by sys_clk. It acts as responder on wshb_if_stream and accepts classic single writes into an internal FIFO. It then replays each write as initiator on wshb_if_sdram, with a fixed base address offset. It replaces the constant tie-offs on both buses in the top level.

## Interface
Parameters:
- DEPTH, 16: FIFO entries; power of two, ≥2.
- BASE_ADDR, 32'h0000_0000: offset added to every incoming address.

Ports:
- sys_clk  input  1  system clock, 100 MHz.
- sys_rst  input  1  reset; asynchronous, active-high.
- wshb_ifs  wshb_if.slave  (DATA_BYTES=4)  stream-side responder port.
- wshb_ifm  wshb_if.master  (DATA_BYTES=4)  SDRAM-side initiator port.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- stat_words  output  32  writes completed on SDRAM side (see Configuration).
- stat_errs  output  16  SDRAM-side err responses (see Configuration).

## Operation
- Write request: wshb_ifs.cyc & stb & we.
- Read request: cyc & stb & ~we.
- Accept rule: ack = write request & ~full, combinational; full is derived from the registered count only.
- On accept, push {adr + BASE_ADDR, dat_ms, sel}. Addition is modulo 2^32 and wraps silently.
- Read requests: err = 1 combinationally, ack = 0; never enqueued.
- Other responder outputs: dat_sm = 0, rty = 0 always.
- Initiator FSM, state IDLE:
  - cyc = stb = we = 0.
  - Go to WRITE when FIFO non-empty; outputs load the head entry.
- Initiator FSM, state WRITE:
  - cyc = stb = we = 1; adr/dat_ms/sel hold the head entry.
  - On ack or err, pop the head.
  - If FIFO non-empty after the pop, stay in WRITE and load the next entry the next cycle. Otherwise return to IDLE.
  - rty is treated as not-ack: hold and retry.
- Err on the initiator side drops the entry: no retry, bump stat_errs.
- cti = 3'b000 and bte = 2'b00 always (classic cycles only).
- Push and pop in the same cycle: level unchanged. This is legal when non-empty and not full.

## Timing
- Reset values:
  - All initiator outputs 0; FSM in IDLE.
  - FIFO empty; level = 0; stats = 0.
  - Responder ack/err/rty = 0 while no request is present.
- Latency: a write accepted at edge N appears on wshb_ifm.cyc/stb at cycle N+1 if the FIFO was empty. Initiator outputs are registered.
- Throughput: one transfer per cycle when the SDRAM acks combinationally.
- Full (level == DEPTH): ack stays low and the stream master stalls. A pop in the same cycle does not enable acceptance until the next cycle.
- Empty: the initiator deasserts cyc/stb in the cycle after the last ack.
- Reset mid-burst: asynchronous.
  - FIFO contents are discarded.
  - cyc/stb drop immediately.
  - No further SDRAM activity after release until a new write is accepted.
- Stats counters wrap around on overflow.

## Configuration
- Macro: WSHB_BRIDGE_STATS_EN.
- When defined: stat_words increments on each initiator ack; stat_errs increments on each initiator err.
- When undefined: both outputs are tied to 0 and the counter logic is absent.
- Data-path behaviour is identical in both builds.

## Structure
- Package wshb_bridge_pkg contains:
  - typedef struct packed fifo_entry_t {adr[31:0], dat[31:0], sel[3:0]};
  - enum state_t {IDLE, WRITE};
  - constant CTI_CLASSIC = 3'b000.
- Sub-module sync_fifo: single-clock, parameterised width/depth, async reset.
  - Inputs: push, pop. Outputs: full, empty, count, head.
  - Read is show-ahead (head valid while non-empty).
- The bridge top holds the ack/err decode, the FSM and the stats counters.

## Test plan
- Single write: stream writes adr=0x10, dat=0xDEADBEEF, sel=4'hF with BASE_ADDR=0x1000 and SDRAM ack in the first cycle. Expect stream ack in the same cycle; SDRAM cyc/stb one cycle later with adr=0x1010, dat=0xDEADBEEF; level returns to 0.
- Back-to-back burst of 20 writes (dat = index) with DEPTH=16 and SDRAM ack withheld:
  - 16 stream acks, then ack low; level = 16.
  - After SDRAM acks resume, all 20 words arrive in order 0..19.
- Read request on the stream port: err = 1, ack = 0, level unchanged, no SDRAM cycle.
- SDRAM returns err on the 2nd of 3 writes: 3rd write is still issued; stat_errs = 1 and stat_words = 2 with WSHB_BRIDGE_STATS_EN; both 0 without it.
- Address wrap: adr=0xFFFF_FFF0, BASE_ADDR=0x20 → SDRAM adr=0x0000_0010.
- Reset mid-operation: assert sys_rst with level = 5 while SDRAM cyc is high. Expect cyc = 0 immediately; level = 0; after release, no SDRAM cycle until a new stream write.

Source files
------------

// File: rtl/wshb_bridge_pkg.sv
// Shared types and constants for the Wishbone stream-to-SDRAM write-posting bridge.
package wshb_bridge_pkg;

    // Only classic single cycles are ever issued on the SDRAM side.
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    // One posted write: translated address, data and byte lanes.
    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } fifo_entry_t;

    localparam int          ENTRY_W    = $bits(fifo_entry_t);
    localparam fifo_entry_t ENTRY_ZERO = '{adr: 32'h0000_0000, dat: 32'h0000_0000, sel: 4'h0};

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    // Address translation into the SDRAM window; wraps modulo 2^32 by design.
    function automatic logic [31:0] offset_addr(input logic [31:0] adr, input logic [31:0] base);
        return adr + base;
    endfunction

endpackage

// File: rtl/wshb_if.sv
// Wishbone B4 bus bundle with initiator (master) and responder (slave) views.
interface wshb_if #(
    parameter int DATA_BYTES = 4
) ();
    logic                      cyc;
    logic                      stb;
    logic                      we;
    logic [31:0]               adr;
    logic [8*DATA_BYTES-1:0]   dat_ms;
    logic [8*DATA_BYTES-1:0]   dat_sm;
    logic [DATA_BYTES-1:0]     sel;
    logic [2:0]                cti;
    logic [1:0]                bte;
    logic                      ack;
    logic                      err;
    logic                      rty;

    modport master (
        output cyc, stb, we, adr, dat_ms, sel, cti, bte,
        input  dat_sm, ack, err, rty
    );

    modport slave (
        input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
        output dat_sm, ack, err, rty
    );
endinterface

// File: rtl/wshb_stream_bridge_fifo.sv
// sync_fifo: single-clock show-ahead FIFO with async active-high reset.
// Besides the head it exposes the entry behind the head so a consumer can
// reload its output registers on the same edge that pops the head.
module sync_fifo #(
    parameter int WIDTH = 68,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head,
    output logic [WIDTH-1:0]         head_next
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;
    logic [AW-1:0]    rd_next_s;

    // Never overrun or underrun, whatever the caller requests.
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign rd_next_s = rd_ptr_r + AW'(1);

    assign full      = (count_r == (AW+1)'(DEPTH));
    assign empty     = (count_r == (AW+1)'(0));
    assign count     = count_r;
    assign head      = mem_r[rd_ptr_r];
    assign head_next = mem_r[rd_next_s];

    // Storage array write port; contents need no reset, validity lives in count_r.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= (AW+1)'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_next_s;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/wshb_stream_bridge.sv
// wshb_stream_bridge: posts classic Wishbone writes from the stream bus into a
// FIFO and replays them, offset by BASE_ADDR, as initiator on the SDRAM bus.
// Optional statistics counters are built when WSHB_BRIDGE_STATS_EN is defined.
module wshb_stream_bridge
    import wshb_bridge_pkg::*;
#(
    parameter int          DEPTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    wshb_if.slave                    wshb_ifs,
    wshb_if.master                   wshb_ifm,
    output logic [$clog2(DEPTH):0]   level,
    output logic [31:0]              stat_words,
    output logic [15:0]              stat_errs
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic                wr_req_s;
    logic                rd_req_s;
    logic                push_s;
    logic                pop_s;
    logic                resp_s;
    logic                more_s;
    logic                full_s;
    logic                empty_s;
    logic [LVL_W-1:0]    count_s;
    fifo_entry_t         push_entry_s;
    fifo_entry_t         head_s;
    fifo_entry_t         head_next_s;

    state_t              state_r;
    state_t              state_nxt_s;
    fifo_entry_t         out_r;
    fifo_entry_t         out_nxt_s;
    logic                cyc_r;
    logic                cyc_nxt_s;
    logic                unused_s;

    // Responder decode: writes are accepted while not full (registered count),
    // reads are refused with err and never enqueued.
    assign wr_req_s        = wshb_ifs.cyc & wshb_ifs.stb & wshb_ifs.we;
    assign rd_req_s        = wshb_ifs.cyc & wshb_ifs.stb & ~wshb_ifs.we;
    assign push_s          = wr_req_s & ~full_s;
    assign wshb_ifs.ack    = push_s;
    assign wshb_ifs.err    = rd_req_s;
    assign wshb_ifs.rty    = 1'b0;
    assign wshb_ifs.dat_sm = 32'h0000_0000;

    assign push_entry_s = '{adr: offset_addr(wshb_ifs.adr, BASE_ADDR),
                            dat: wshb_ifs.dat_ms,
                            sel: wshb_ifs.sel};

    // rty is deliberately not a completion: the entry stays and is re-presented.
    assign resp_s = (state_r == WRITE) & (wshb_ifm.ack | wshb_ifm.err);
    assign pop_s  = resp_s;
    assign more_s = (count_s > LVL_W'(1));

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (sys_clk),
        .rst       (sys_rst),
        .push      (push_s),
        .pop       (pop_s),
        .din       (push_entry_s),
        .full      (full_s),
        .empty     (empty_s),
        .count     (count_s),
        .head      (head_s),
        .head_next (head_next_s)
    );

    assign level = count_s;

    // FSM state register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: stay in WRITE while something remains after the pop.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (!empty_s) begin
                    state_nxt_s = WRITE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WRITE: begin
                if (resp_s) begin
                    if (more_s || push_s) begin
                        state_nxt_s = WRITE;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = WRITE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs: pick the entry to present next cycle. After a pop the new
    // head is either the entry behind the old head or, if the FIFO held only
    // one entry, the write being accepted on this same edge.
    always_comb begin
        out_nxt_s = out_r;
        cyc_nxt_s = cyc_r;
        case (state_r)
            IDLE: begin
                if (!empty_s) begin
                    out_nxt_s = head_s;
                    cyc_nxt_s = 1'b1;
                end else begin
                    out_nxt_s = ENTRY_ZERO;
                    cyc_nxt_s = 1'b0;
                end
            end
            WRITE: begin
                if (resp_s) begin
                    if (more_s) begin
                        out_nxt_s = head_next_s;
                        cyc_nxt_s = 1'b1;
                    end else if (push_s) begin
                        out_nxt_s = push_entry_s;
                        cyc_nxt_s = 1'b1;
                    end else begin
                        out_nxt_s = ENTRY_ZERO;
                        cyc_nxt_s = 1'b0;
                    end
                end else begin
                    out_nxt_s = out_r;
                    cyc_nxt_s = 1'b1;
                end
            end
            default: begin
                out_nxt_s = ENTRY_ZERO;
                cyc_nxt_s = 1'b0;
            end
        endcase
    end

    // Initiator output registers; reset drops cyc/stb immediately.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            out_r <= ENTRY_ZERO;
            cyc_r <= 1'b0;
        end else begin
            out_r <= out_nxt_s;
            cyc_r <= cyc_nxt_s;
        end
    end

    assign wshb_ifm.cyc    = cyc_r;
    assign wshb_ifm.stb    = cyc_r;
    assign wshb_ifm.we     = cyc_r;
    assign wshb_ifm.adr    = out_r.adr;
    assign wshb_ifm.dat_ms = out_r.dat;
    assign wshb_ifm.sel    = out_r.sel;
    assign wshb_ifm.cti    = CTI_CLASSIC;
    assign wshb_ifm.bte    = BTE_LINEAR;

`ifdef WSHB_BRIDGE_STATS_EN
    logic [31:0] words_r;
    logic [15:0] errs_r;

    // Completion and error counters; both wrap silently.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            words_r <= 32'h0000_0000;
            errs_r  <= 16'h0000;
        end else begin
            if ((state_r == WRITE) && wshb_ifm.ack) begin
                words_r <= words_r + 32'd1;
            end
            if ((state_r == WRITE) && wshb_ifm.err) begin
                errs_r <= errs_r + 16'd1;
            end
        end
    end

    assign stat_words = words_r;
    assign stat_errs  = errs_r;
`else
    assign stat_words = 32'h0000_0000;
    assign stat_errs  = 16'h0000;
`endif

    // Bus fields this bridge has no use for (read data, retry, burst hints).
    assign unused_s = ^{wshb_ifm.dat_sm, wshb_ifm.rty, wshb_ifs.cti, wshb_ifs.bte};

endmodule

// File: tb/tb_wshb_stream_bridge.sv
// Self-checking bench for wshb_stream_bridge (DEPTH=16, BASE_ADDR=0x1000).
module tb_wshb_stream_bridge;
    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } ent_t;

    typedef struct {
        logic cyc, stb, we;
        logic ack, err;
    } vec_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        s_cyc = 1'b0, s_stb = 1'b0, s_we = 1'b0;
    logic [31:0] s_adr = 32'h0, s_dat = 32'h0;
    logic [3:0]  s_sel = 4'h0;
    logic [1:0]  m_resp = 2'd0;   // 0 none, 1 ack, 2 err, 3 rty
    logic [4:0]  level;
    logic [31:0] stat_words;
    logic [15:0] stat_errs;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: posted writes not yet completed, and the occupancy
    // during the previous cycle (the initiator needs a cycle to see new data)
    ent_t        q[$];
    int          prev_level = 0;
    logic [31:0] exp_words = 32'h0;
    logic [15:0] exp_errs = 16'h0;
    logic [31:0] obs_q[$];

    wshb_if #(.DATA_BYTES(4)) ifs_bus ();
    wshb_if #(.DATA_BYTES(4)) ifm_bus ();

    assign ifs_bus.cyc    = s_cyc;
    assign ifs_bus.stb    = s_stb;
    assign ifs_bus.we     = s_we;
    assign ifs_bus.adr    = s_adr;
    assign ifs_bus.dat_ms = s_dat;
    assign ifs_bus.sel    = s_sel;
    assign ifs_bus.cti    = 3'b000;
    assign ifs_bus.bte    = 2'b00;

    assign ifm_bus.ack    = ifm_bus.cyc & ifm_bus.stb & (m_resp == 2'd1);
    assign ifm_bus.err    = ifm_bus.cyc & ifm_bus.stb & (m_resp == 2'd2);
    assign ifm_bus.rty    = ifm_bus.cyc & ifm_bus.stb & (m_resp == 2'd3);
    assign ifm_bus.dat_sm = 32'h0;

    wshb_stream_bridge #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .wshb_ifs   (ifs_bus),
        .wshb_ifm   (ifm_bus),
        .level      (level),
        .stat_words (stat_words),
        .stat_errs  (stat_errs)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((level != 5'd0 || ifm_bus.cyc) && n < budget) begin
            step();
            n++;
        end
        chk("drain_within_budget", {63'd0, (level == 5'd0 && !ifm_bus.cyc)}, 64'd1);
    endtask

    // model update at each edge: accept while below DEPTH, complete on ack/err
    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            q.delete();
            prev_level = 0;
            exp_words  = 32'h0;
            exp_errs   = 16'h0;
        end else begin
            automatic bit busy = (prev_level > 0) && (q.size() > 0);
            automatic bit acc  = s_cyc && s_stb && s_we && (q.size() < DEPTH);
            automatic int lvl  = q.size();
            if (busy && (m_resp == 2'd1 || m_resp == 2'd2)) begin
                void'(q.pop_front());
                if (m_resp == 2'd1) exp_words = exp_words + 32'd1;
                else                exp_errs  = exp_errs + 16'd1;
            end
            if (acc) q.push_back('{adr: s_adr + BASE, dat: s_dat, sel: s_sel});
            prev_level = lvl;
        end
    end

    // continuous comparison against the model, away from the active edge
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            automatic bit busy = (prev_level > 0) && (q.size() > 0);
            chk("ifs_ack", {63'd0, ifs_bus.ack}, {63'd0, (s_cyc && s_stb && s_we && q.size() < DEPTH)});
            chk("ifs_err", {63'd0, ifs_bus.err}, {63'd0, (s_cyc && s_stb && !s_we)});
            chk("ifs_rty", {63'd0, ifs_bus.rty}, 64'd0);
            chk("ifs_dat_sm", {32'd0, ifs_bus.dat_sm}, 64'd0);
            chk("level", {59'd0, level}, 64'(q.size()));
            chk("ifm_cyc", {63'd0, ifm_bus.cyc}, {63'd0, busy});
            chk("ifm_stb", {63'd0, ifm_bus.stb}, {63'd0, busy});
            chk("ifm_we", {63'd0, ifm_bus.we}, {63'd0, busy});
            chk("ifm_cti_bte", {59'd0, ifm_bus.cti, ifm_bus.bte}, 64'd0);
            if (busy) begin
                chk("ifm_adr", {32'd0, ifm_bus.adr}, {32'd0, q[0].adr});
                chk("ifm_dat", {32'd0, ifm_bus.dat_ms}, {32'd0, q[0].dat});
                chk("ifm_sel", {60'd0, ifm_bus.sel}, {60'd0, q[0].sel});
            end
`ifdef WSHB_BRIDGE_STATS_EN
            chk("stat_words", {32'd0, stat_words}, {32'd0, exp_words});
            chk("stat_errs", {48'd0, stat_errs}, {48'd0, exp_errs});
`else
            chk("stat_words", {32'd0, stat_words}, 64'd0);
            chk("stat_errs", {48'd0, stat_errs}, 64'd0);
`endif
            if (ifm_bus.cyc && ifm_bus.stb && (ifm_bus.ack || ifm_bus.err))
                obs_q.push_back(ifm_bus.dat_ms);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, 0 expected");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[8];
        int   idx;
        logic got;

        tbl[0] = '{cyc: 1'b0, stb: 1'b0, we: 1'b0, ack: 1'b0, err: 1'b0};
        tbl[1] = '{cyc: 1'b0, stb: 1'b0, we: 1'b1, ack: 1'b0, err: 1'b0};
        tbl[2] = '{cyc: 1'b0, stb: 1'b1, we: 1'b0, ack: 1'b0, err: 1'b0};
        tbl[3] = '{cyc: 1'b0, stb: 1'b1, we: 1'b1, ack: 1'b0, err: 1'b0};
        tbl[4] = '{cyc: 1'b1, stb: 1'b0, we: 1'b0, ack: 1'b0, err: 1'b0};
        tbl[5] = '{cyc: 1'b1, stb: 1'b0, we: 1'b1, ack: 1'b0, err: 1'b0};
        tbl[6] = '{cyc: 1'b1, stb: 1'b1, we: 1'b0, ack: 1'b0, err: 1'b1};
        tbl[7] = '{cyc: 1'b1, stb: 1'b1, we: 1'b1, ack: 1'b1, err: 1'b0};

        // reset state
        step();
        step();
        chk("rst_cyc", {63'd0, ifm_bus.cyc}, 64'd0);
        chk("rst_ifm_out", {ifm_bus.adr, ifm_bus.dat_ms}, 64'd0);
        chk("rst_level", {59'd0, level}, 64'd0);
        chk("rst_stats", {16'd0, stat_errs, stat_words}, 64'd0);
        chk("rst_ifs_resp", {61'd0, ifs_bus.ack, ifs_bus.err, ifs_bus.rty}, 64'd0);
        sys_rst = 1'b0;
        step();

        // responder decode table, SDRAM acking so the FIFO never fills
        m_resp = 2'd1;
        for (int i = 0; i < 8; i++) begin
            s_cyc = tbl[i].cyc; s_stb = tbl[i].stb; s_we = tbl[i].we;
            s_adr = $urandom; s_dat = $urandom; s_sel = 4'($urandom);
            #1;
            chk("tbl_ack", {63'd0, ifs_bus.ack}, {63'd0, tbl[i].ack});
            chk("tbl_err", {63'd0, ifs_bus.err}, {63'd0, tbl[i].err});
            step();
        end
        s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
        wait_drain(10);

        // single write: ack same cycle, SDRAM cycle after the accept edge + 1
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b1;
        s_adr = 32'h10; s_dat = 32'hDEAD_BEEF; s_sel = 4'hF;
        #1;
        chk("single_ack", {63'd0, ifs_bus.ack}, 64'd1);
        step();
        s_cyc = 1'b0; s_stb = 1'b0;
        chk("single_lvl1", {59'd0, level}, 64'd1);
        chk("single_cyc_not_yet", {63'd0, ifm_bus.cyc}, 64'd0);
        step();
        chk("single_cyc", {63'd0, ifm_bus.cyc}, 64'd1);
        chk("single_adr", {32'd0, ifm_bus.adr}, 64'h1010);
        chk("single_dat", {32'd0, ifm_bus.dat_ms}, 64'hDEAD_BEEF);
        step();
        chk("single_idle", {59'd0, level, ifm_bus.cyc}, 64'd0);

        // burst of 20 with SDRAM stalled: 16 accepted, then in-order drain
        m_resp = 2'd0;
        obs_q.delete();
        idx = 0;
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b1; s_sel = 4'hF;
        for (int c = 0; c < 24; c++) begin
            s_dat = 32'(idx); s_adr = 32'(idx * 4);
            @(negedge sys_clk);
            got = ifs_bus.ack;
            step();
            if (got) idx++;
        end
        chk("burst_accepted", 64'(idx), 64'd16);
        chk("burst_level_full", {59'd0, level}, 64'd16);
        chk("burst_ack_low_full", {63'd0, ifs_bus.ack}, 64'd0);
        m_resp = 2'd1;
        for (int c = 0; c < 40 && idx < 20; c++) begin
            s_dat = 32'(idx); s_adr = 32'(idx * 4);
            @(negedge sys_clk);
            got = ifs_bus.ack;
            step();
            if (got) idx++;
        end
        s_cyc = 1'b0; s_stb = 1'b0;
        wait_drain(40);
        chk("burst_count", 64'(obs_q.size()), 64'd20);
        for (int i = 0; i < 20 && i < obs_q.size(); i++)
            chk("burst_order", {32'd0, obs_q[i]}, 64'(i));

        // read request: err, no ack, nothing queued
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("read_err", {62'd0, ifs_bus.err, ifs_bus.ack}, 64'd2);
            step();
            chk("read_no_queue", {59'd0, level, ifm_bus.cyc}, 64'd0);
        end
        s_cyc = 1'b0; s_stb = 1'b0;

        // address wrap modulo 2^32
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b1; s_adr = 32'hFFFF_F010; s_dat = 32'h5A5A_0001;
        step();
        s_cyc = 1'b0; s_stb = 1'b0;
        step();
        chk("wrap_adr", {31'd0, ifm_bus.cyc, ifm_bus.adr}, 64'h1_0000_0010);
        wait_drain(10);

        // reset with 5 posted entries and an SDRAM cycle in flight
        m_resp = 2'd0;
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b1;
        for (int c = 0; c < 5; c++) begin
            s_dat = 32'(c + 100);
            step();
        end
        s_cyc = 1'b0; s_stb = 1'b0;
        chk("pre_rst_state", {58'd0, level, ifm_bus.cyc}, {58'd0, 5'd5, 1'b1});
        sys_rst = 1'b1;
        #1;
        chk("rst_async_cyc", {62'd0, ifm_bus.cyc, ifm_bus.stb}, 64'd0);
        chk("rst_async_level", {59'd0, level}, 64'd0);
        step();
        step();
        sys_rst = 1'b0;
        m_resp = 2'd1;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("post_rst_quiet", {63'd0, ifm_bus.cyc}, 64'd0);
        end

        // err on the 2nd of 3 writes: 3rd still issued, stats from reset
        m_resp = 2'd0;
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b1;
        for (int c = 0; c < 3; c++) begin
            s_dat = 32'hA0 + 32'(c);
            step();
        end
        s_cyc = 1'b0; s_stb = 1'b0;
        obs_q.delete();
        for (int c = 0; c < 20 && (level != 5'd0 || ifm_bus.cyc); c++) begin
            m_resp = (obs_q.size() == 1) ? 2'd2 : 2'd1;
            step();
        end
        chk("err_all_issued", 64'(obs_q.size()), 64'd3);
        if (obs_q.size() == 3)
            chk("err_seq", {obs_q[1], obs_q[2]}, {32'hA1, 32'hA2});
`ifdef WSHB_BRIDGE_STATS_EN
        chk("err_stat_words", {32'd0, stat_words}, 64'd2);
        chk("err_stat_errs", {48'd0, stat_errs}, 64'd1);
`else
        chk("err_stat_words", {32'd0, stat_words}, 64'd0);
        chk("err_stat_errs", {48'd0, stat_errs}, 64'd0);
`endif

        // randomized traffic, with periodic SDRAM stalls so the FIFO fills
        for (int c = 0; c < 1500; c++) begin
            s_cyc = ($urandom_range(0, 9) > 1);
            s_stb = ($urandom_range(0, 9) > 0);
            s_we  = ($urandom_range(0, 9) > 0);
            s_adr = $urandom; s_dat = $urandom; s_sel = 4'($urandom);
            if (((c / 100) % 3) == 2) begin
                m_resp = ($urandom_range(0, 9) == 0) ? 2'd1 : 2'd0;
            end else begin
                case ($urandom_range(0, 9))
                    0, 1:    m_resp = 2'd0;
                    2:       m_resp = 2'd2;
                    3, 4:    m_resp = 2'd3;
                    default: m_resp = 2'd1;
                endcase
            end
            step();
        end
        s_cyc = 1'b0; s_stb = 1'b0;
        m_resp = 2'd1;
        wait_drain(40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
